sync_checker: RTL and testbench

Downstream consumer for the synchronizer outputs: a receive-side checker sampled in the destination clock domain (the `clk_2` side of the synchronizers). It takes each word delivered by a synchronizer, together with its one-cycle valid pulse, and compares it against the expected next value of a known source sequence. The source sequence is a +1 count by default, or PRBS-8 when configured. The checker locks onto the stream, counts delivered words and corrupted words, and flags loss of lock, so metastability-induced failures can be measured on silicon per synchronizer flavour.

---
 rtl/sync_checker_pkg.sv | 46 ++++
 rtl/sync_checker_if.sv | 20 ++
 rtl/sync_checker_sat_counter.sv | 31 +++
 rtl/sync_checker.sv | 202 ++++++++++++++++++++
 tb/tb_sync_checker.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_checker_pkg.sv
// -----------------------------------------------------------------------------
// sync_pkg -- shared definitions for the sync_checker receive-side checker.
//
// Contents:
//   chk_state_t : checker FSM state (HUNT, LOCKED)
//   PRBS8_TAPS  : tap mask of the PRBS-8 polynomial x^8+x^6+x^5+x^4+1
//   nxt()       : successor of a word in the source sequence
//
// Build option: SYNC_CHECKER_PRBS_EN
//   defined   -> nxt() is one PRBS-8 LFSR step (8-bit words only)
//   undefined -> nxt() is +1 modulo 2^width
// -----------------------------------------------------------------------------
package sync_pkg;

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    // Bits 7, 5, 4 and 3 feed the XOR that becomes the new LSB.
    localparam logic [7:0] PRBS8_TAPS = 8'b1011_1000;

    // Widest word the successor function handles.
    localparam int unsigned NXT_MAX_W = 64;

    // The word is carried in a 64-bit container so one function serves every
    // word width; callers truncate the result back to their own width.
    function automatic logic [63:0] nxt(input logic [63:0] x, input int unsigned width);
        logic [63:0] r;
        r = '0;
`ifdef SYNC_CHECKER_PRBS_EN
        r[7:0]  = {x[6:0], ^(x[7:0] & PRBS8_TAPS)};
        r[63:8] = x[63:8] & 56'd0;
        if (width != 32'd8) begin
            r = '0;
        end
`else
        r = x + 64'd1;
        if (width < NXT_MAX_W) begin
            r = r & ((64'd1 << width) - 64'd1);
        end
`endif
        return r;
    endfunction

endpackage

// File: rtl/sync_checker_if.sv
// -----------------------------------------------------------------------------
// sync_checker_if -- word stream delivered by a synchronizer output.
//
// Signals:
//   data_in  [N] : word from the synchronizer
//   valid_in     : one-cycle pulse, data_in is a new word this cycle
//
// Modports:
//   master : the synchronizer side (drives the stream)
//   slave  : the checker side (observes the stream)
// -----------------------------------------------------------------------------
interface sync_checker_if #(
    parameter int N = 8
);
    logic [N-1:0] data_in;
    logic         valid_in;

    modport master (output data_in, output valid_in);
    modport slave  (input  data_in, input  valid_in);
endinterface

// File: rtl/sync_checker_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter -- up counter that sticks at all-ones.
//
// Ports:
//   clk         : clock, rising edge
//   clr         : synchronous clear to zero (wins over inc)
//   inc         : add one this cycle unless already at all-ones
//   count [WIDTH] : registered count value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            count_reg <= '0;
        end else if (inc && !(&count_reg)) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/sync_checker.sv
// -----------------------------------------------------------------------------
// sync_checker -- destination-domain checker for synchronizer output streams.
//
// Compares every delivered word against the expected successor of a known
// source sequence (+1 count, or PRBS-8 when SYNC_CHECKER_PRBS_EN is defined),
// locks onto the stream, counts accepted and corrupted words and reports loss
// of lock.
//
// Ports:
//   clk            : destination-domain clock, rising edge
//   rst            : synchronous active-high reset
//   ena            : block enable; low holds all state and ignores inputs
//   clear          : synchronous clear of counters and FSM (needs ena)
//   bus            : sync_checker_if.slave (data_in, valid_in)
//   locked         : FSM is in LOCKED
//   err_pulse      : one-cycle pulse per counted mismatch
//   word_cnt [CNT_W] : accepted words since reset/clear, saturating
//   err_cnt  [CNT_W] : mismatches while LOCKED, saturating
//   last_bad [N]   : most recent mismatching word seen while LOCKED
//
// Build option: SYNC_CHECKER_PRBS_EN selects the PRBS-8 source sequence
// (N must then be 8); otherwise the source is a +1 count.
// -----------------------------------------------------------------------------
module sync_checker
    import sync_pkg::*;
#(
    parameter int N      = 8,
    parameter int CNT_W  = 16,
    parameter int LOCK_N = 4,
    parameter int LOSS_N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             clear,
    sync_checker_if.slave    bus,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [N-1:0]     last_bad
);

    // ---------------------------------------------------------------- checks
    if (LOCK_N < 1 || LOCK_N > 15) begin : g_bad_lock_n
        $error("sync_checker: LOCK_N must be in 1..15");
    end
    if (LOSS_N < 1 || LOSS_N > 15) begin : g_bad_loss_n
        $error("sync_checker: LOSS_N must be in 1..15");
    end
`ifdef SYNC_CHECKER_PRBS_EN
    if (N != 8) begin : g_bad_prbs_width
        $error("sync_checker: PRBS-8 source requires N == 8");
    end
`else
    if (N < 2 || N > 64) begin : g_bad_width
        $error("sync_checker: N must be in 2..64");
    end
`endif

    localparam logic [3:0] LOCK_RUN = 4'(LOCK_N);
    localparam logic [3:0] LOSS_RUN = 4'(LOSS_N);

    // ------------------------------------------------------------- registers
    chk_state_t   state_reg,     state_next;
    logic         seeded_reg,    seeded_next;
    logic [N-1:0] expected_reg,  expected_next;
    logic [3:0]   run_reg,       run_next;
    logic [N-1:0] last_bad_reg,  last_bad_next;
    logic         err_pulse_reg, err_pulse_next;

    // ------------------------------------------------------- decoded inputs
    logic         accept;
    logic         clr_all;
    logic         err_inc;
    logic         word_match;
    logic [3:0]   run_inc;
    logic [N-1:0] nxt_data;
    logic [N-1:0] nxt_exp;

    assign accept  = ena && bus.valid_in && !clear;
    assign clr_all = rst || (ena && clear);
    assign run_inc = run_reg + 4'd1;

    assign nxt_data = N'(nxt(64'(bus.data_in), N));
    assign nxt_exp  = N'(nxt(64'(expected_reg), N));

`ifdef SYNC_CHECKER_PRBS_EN
    // The all-zero word is the LFSR lock-up state and can never follow a real
    // sequence word, so it is never treated as in-sequence.
    assign word_match = (bus.data_in == expected_reg) && (|bus.data_in);
`else
    assign word_match = (bus.data_in == expected_reg);
`endif

    // ---------------------------------------------------- next-state logic
    always_comb begin
        state_next     = state_reg;
        seeded_next    = seeded_reg;
        expected_next  = expected_reg;
        run_next       = run_reg;
        last_bad_next  = last_bad_reg;
        err_pulse_next = 1'b0;
        err_inc        = 1'b0;

        if (ena && clear) begin
            state_next    = HUNT;
            seeded_next   = 1'b0;
            expected_next = '0;
            run_next      = '0;
            last_bad_next = '0;
        end else if (accept) begin
            unique case (state_reg)
                HUNT: begin
                    // While hunting, the prediction always re-seeds from the
                    // received word so a single good pair can start a run.
                    expected_next = nxt_data;
                    if (!seeded_reg) begin
                        seeded_next = 1'b1;
                        run_next    = '0;
                    end else if (word_match) begin
                        if (run_inc == LOCK_RUN) begin
                            state_next = LOCKED;
                            run_next   = '0;
                        end else begin
                            run_next = run_inc;
                        end
                    end else begin
                        run_next = '0;
                    end
                end
                LOCKED: begin
                    // Free-running prediction: a corrupted word does not
                    // disturb the expectation of the words that follow it.
                    expected_next = nxt_exp;
                    if (word_match) begin
                        run_next = '0;
                    end else begin
                        err_inc        = 1'b1;
                        err_pulse_next = 1'b1;
                        last_bad_next  = bus.data_in;
                        if (run_inc == LOSS_RUN) begin
                            state_next  = HUNT;
                            seeded_next = 1'b0;
                            run_next    = '0;
                        end else begin
                            run_next = run_inc;
                        end
                    end
                end
                default: begin
                    state_next = HUNT;
                end
            endcase
        end
    end

    // ------------------------------------------------------- state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= HUNT;
            seeded_reg    <= 1'b0;
            expected_reg  <= '0;
            run_reg       <= '0;
            last_bad_reg  <= '0;
            err_pulse_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            seeded_reg    <= seeded_next;
            expected_reg  <= expected_next;
            run_reg       <= run_next;
            last_bad_reg  <= last_bad_next;
            err_pulse_reg <= err_pulse_next;
        end
    end

    // ------------------------------------------------------------- counters
    // Index 0 counts accepted words, index 1 counts errors while locked.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc = {err_inc, accept};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        sat_counter #(
            .WIDTH (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .clr   (clr_all),
            .inc   (cnt_inc[gi]),
            .count (cnt_val[gi])
        );
    end

    // -------------------------------------------------------------- outputs
    assign locked    = (state_reg == LOCKED);
    assign err_pulse = err_pulse_reg;
    assign word_cnt  = cnt_val[0];
    assign err_cnt   = cnt_val[1];
    assign last_bad  = last_bad_reg;

endmodule

// File: tb/tb_sync_checker.sv
// -----------------------------------------------------------------------------
// tb_sync_checker -- directed self-checking bench for sync_checker.
// A reference model produces the expected outputs of each driven cycle; they
// are queued when the stimulus is applied and compared after the clock edge.
// A second instance (CNT_W=4, LOSS_N=15) exercises counter saturation.
// Build option SYNC_CHECKER_PRBS_EN switches both model and stimulus seeds.
// -----------------------------------------------------------------------------
module tb_sync_checker;

    localparam int N      = 8;
    localparam int LOCK_N = 4;
    localparam int LOSS_N = 4;

`ifdef SYNC_CHECKER_PRBS_EN
    localparam logic [7:0] SEED_A = 8'h01;
    localparam logic [7:0] SEED_B = 8'h05;
    localparam logic [7:0] SEED_C = 8'h40;
`else
    localparam logic [7:0] SEED_A = 8'h10;
    localparam logic [7:0] SEED_B = 8'h30;
    localparam logic [7:0] SEED_C = 8'h40;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ena;
    logic        clear;
    logic        locked;
    logic        err_pulse;
    logic [15:0] word_cnt;
    logic [15:0] err_cnt;
    logic [7:0]  last_bad;

    logic        locked2;
    logic        err_pulse2;
    logic [3:0]  word_cnt2;
    logic [3:0]  err_cnt2;
    logic [7:0]  last_bad2;

    sync_checker_if #(.N(N)) bus1 ();
    sync_checker_if #(.N(N)) bus2 ();

    sync_checker #(
        .N(N), .CNT_W(16), .LOCK_N(LOCK_N), .LOSS_N(LOSS_N)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .clear(clear), .bus(bus1),
        .locked(locked), .err_pulse(err_pulse), .word_cnt(word_cnt),
        .err_cnt(err_cnt), .last_bad(last_bad)
    );

    sync_checker #(
        .N(N), .CNT_W(4), .LOCK_N(4), .LOSS_N(15)
    ) dut_sat (
        .clk(clk), .rst(rst), .ena(1'b1), .clear(1'b0), .bus(bus2),
        .locked(locked2), .err_pulse(err_pulse2), .word_cnt(word_cnt2),
        .err_cnt(err_cnt2), .last_bad(last_bad2)
    );

    // ----------------------------------------------------------- scoreboard
    typedef struct {
        logic        locked;
        logic        err_pulse;
        logic [15:0] word_cnt;
        logic [15:0] err_cnt;
        logic [7:0]  last_bad;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    // reference model state
    logic       m_locked = 1'b0;
    logic       m_seeded = 1'b0;
    logic [7:0] m_exp    = 8'h00;
    int         m_run    = 0;
    int         m_wc     = 0;
    int         m_ec     = 0;
    logic [7:0] m_lb     = 8'h00;
    logic       m_pulse  = 1'b0;

    function automatic logic [7:0] tb_nxt(input logic [7:0] x);
`ifdef SYNC_CHECKER_PRBS_EN
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
`else
        return x + 8'd1;
`endif
    endfunction

    function automatic logic tb_match(input logic [7:0] d, input logic [7:0] e);
`ifdef SYNC_CHECKER_PRBS_EN
        return (d == e) && (d != 8'h00);
`else
        return (d == e);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0; m_seeded = 1'b0; m_exp = 8'h00; m_run = 0;
        m_wc = 0; m_ec = 0; m_lb = 8'h00; m_pulse = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic c, input logic e);
        logic mt;
        m_pulse = 1'b0;
        if (!e) begin
            return;
        end
        if (c) begin
            model_reset();
            return;
        end
        if (!v) begin
            return;
        end
        if (m_wc < 65535) m_wc++;
        mt = tb_match(d, m_exp);
        if (!m_locked) begin
            if (!m_seeded) begin
                m_seeded = 1'b1;
                m_run = 0;
            end else if (mt) begin
                m_run++;
                if (m_run == LOCK_N) begin
                    m_locked = 1'b1;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            m_exp = tb_nxt(d);
        end else begin
            m_exp = tb_nxt(m_exp);
            if (mt) begin
                m_run = 0;
            end else begin
                if (m_ec < 65535) m_ec++;
                m_pulse = 1'b1;
                m_lb = d;
                m_run++;
                if (m_run == LOSS_N) begin
                    m_locked = 1'b0;
                    m_seeded = 1'b0;
                    m_run = 0;
                end
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic drive(input logic v, input logic [7:0] d, input logic c,
                         input logic e, input string tag);
        exp_t x;
        bus1.valid_in = v;
        bus1.data_in  = d;
        clear         = c;
        ena           = e;
        model_step(v, d, c, e);
        x.locked = m_locked; x.err_pulse = m_pulse; x.word_cnt = 16'(m_wc);
        x.err_cnt = 16'(m_ec); x.last_bad = m_lb;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            x = sb_q.pop_front();
            chk({tag, "_locked"},   32'(locked),    32'(x.locked));
            chk({tag, "_pulse"},    32'(err_pulse), 32'(x.err_pulse));
            chk({tag, "_word_cnt"}, 32'(word_cnt),  32'(x.word_cnt));
            chk({tag, "_err_cnt"},  32'(err_cnt),   32'(x.err_cnt));
            chk({tag, "_last_bad"}, 32'(last_bad),  32'(x.last_bad));
        end
        $display("%-10s v=%b d=%02h clr=%b ena=%b -> locked=%b pulse=%b wc=%0d ec=%0d lb=%02h",
                 tag, v, d, c, e, locked, err_pulse, word_cnt, err_cnt, last_bad);
        @(negedge clk);
        bus1.valid_in = 1'b0;
        clear         = 1'b0;
        ena           = 1'b1;
    endtask

    task automatic lock_from(input logic [7:0] seed, input string tag);
        logic [7:0] d;
        d = seed;
        for (int i = 0; i < LOCK_N + 1; i++) begin
            drive(1'b1, d, 1'b0, 1'b1, tag);
            d = tb_nxt(d);
        end
    endtask

    task automatic send2(input logic [7:0] d);
        bus2.valid_in = 1'b1;
        bus2.data_in  = d;
        @(posedge clk);
        #1;
        $display("sat        d=%02h -> locked=%b pulse=%b wc=%0d ec=%0d",
                 d, locked2, err_pulse2, word_cnt2, err_cnt2);
        @(negedge clk);
        bus2.valid_in = 1'b0;
    endtask

    // ------------------------------------------------------------- stimulus
    initial begin
        logic [7:0] e2;
        logic [7:0] d;

        rst = 1'b1; ena = 1'b1; clear = 1'b0;
        bus1.valid_in = 1'b0; bus1.data_in = 8'h00;
        bus2.valid_in = 1'b0; bus2.data_in = 8'h00;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked",   32'(locked),    32'd0);
        chk("rst_pulse",    32'(err_pulse), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt),  32'd0);
        chk("rst_err_cnt",  32'(err_cnt),   32'd0);
        chk("rst_last_bad", 32'(last_bad),  32'd0);
        chk("rst_sat_wc",   32'(word_cnt2), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Lock onto a clean stream.
        lock_from(SEED_A, "lock");
        chk("lock_locked_final", 32'(locked),   32'd1);
        chk("lock_word_cnt_5",   32'(word_cnt), 32'd5);
        chk("lock_err_cnt_0",    32'(err_cnt),  32'd0);

        // Single corrupted word costs exactly one error.
        d = m_exp;
        drive(1'b1, d, 1'b0, 1'b1, "corr_ok");
        drive(1'b1, 8'h99, 1'b0, 1'b1, "corr_bad");
        drive(1'b1, m_exp, 1'b0, 1'b1, "corr_ok2");
        drive(1'b0, 8'h00, 1'b0, 1'b1, "idle");
        chk("corr_err_cnt_1",  32'(err_cnt),  32'd1);
        chk("corr_last_bad",   32'(last_bad), 32'h99);
        chk("corr_still_lock", 32'(locked),   32'd1);

        // Loss of lock after LOSS_N consecutive bad words, then relock.
        drive(1'b0, 8'h00, 1'b1, 1'b1, "clear");
        lock_from(SEED_B, "lock_b");
        for (int i = 0; i < LOSS_N; i++) begin
            drive(1'b1, 8'h00, 1'b0, 1'b1, "loss");
        end
        chk("loss_err_cnt_4", 32'(err_cnt), 32'd4);
        chk("loss_unlocked",  32'(locked),  32'd0);
        lock_from(SEED_C, "relock");
        chk("relock_locked",  32'(locked),  32'd1);

        // Back-to-back mismatches give back-to-back pulses.
        drive(1'b1, 8'h00, 1'b0, 1'b1, "b2b_1");
        drive(1'b1, 8'h00, 1'b0, 1'b1, "b2b_2");
        drive(1'b0, 8'h00, 1'b0, 1'b1, "b2b_idle");

`ifdef SYNC_CHECKER_PRBS_EN
        // +1 count and all-zero words must never lock in PRBS mode.
        drive(1'b0, 8'h00, 1'b1, 1'b1, "clear");
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(8'h20 + i), 1'b0, 1'b1, "prbs_inc");
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'h00, 1'b0, 1'b1, "prbs_zero");
        end
        chk("prbs_never_lock", 32'(locked), 32'd0);
`else
        // Wrap from 0xFF to 0x00 is in sequence.
        drive(1'b0, 8'h00, 1'b1, 1'b1, "clear");
        lock_from(8'hFC, "wrap");
        drive(1'b1, 8'h01, 1'b0, 1'b1, "wrap_next");
        chk("wrap_locked",  32'(locked),  32'd1);
        chk("wrap_err_cnt", 32'(err_cnt), 32'd0);
`endif

        // Clear coincident with a valid word while locked.
        drive(1'b0, 8'h00, 1'b1, 1'b1, "clear");
        lock_from(SEED_A, "lock_c");
        drive(1'b1, 8'h00, 1'b0, 1'b1, "pre_clr");
        drive(1'b1, m_exp, 1'b1, 1'b1, "clr_valid");
        chk("clr_word_cnt", 32'(word_cnt), 32'd0);
        chk("clr_err_cnt",  32'(err_cnt),  32'd0);
        chk("clr_locked",   32'(locked),   32'd0);
        chk("clr_last_bad", 32'(last_bad), 32'd0);

        // Enable low: valids and clear are ignored, pulse drops.
        lock_from(SEED_A, "lock_e");
        drive(1'b1, 8'h00, 1'b0, 1'b1, "ena_bad");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h00, 1'b0, 1'b0, "ena_off");
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0, "ena_off_c");
        chk("ena_word_cnt", 32'(word_cnt), 32'd6);
        chk("ena_err_cnt",  32'(err_cnt),  32'd1);
        chk("ena_locked",   32'(locked),   32'd1);

        // Saturation on the narrow-counter instance.
        e2 = SEED_A;
        for (int i = 0; i < 5; i++) begin
            send2(e2);
            e2 = tb_nxt(e2);
        end
        chk("sat_locked_init", 32'(locked2), 32'd1);
        for (int i = 0; i < 21; i++) begin
            if (i == 10) begin
                send2(e2);
            end else begin
                send2(8'h00);
            end
            e2 = tb_nxt(e2);
        end
        chk("sat_err_cnt",  32'(err_cnt2),   32'hF);
        chk("sat_word_cnt", 32'(word_cnt2),  32'hF);
        chk("sat_pulse",    32'(err_pulse2), 32'd1);
        chk("sat_locked",   32'(locked2),    32'd1);
        chk("sat_last_bad", 32'(last_bad2),  32'h00);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
